// File: rtl/w65816_bus_sequencer.sv
// w65816_bus_sequencer: runs one 65C816 PHI2 bus cycle per accepted command, with RDY stretching and a wait timeout
module w65816_bus_sequencer #(
  parameter int CLK_DIV    = 4,
  parameter int WAIT_LIMIT = 16
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [23:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        bus_phi2,
  output logic [15:0] bus_addr,
  output logic        bus_rwb,
  output logic        bus_vda,
  output logic [7:0]  bus_d_out,
  output logic        bus_d_oe,
  input  logic [7:0]  bus_d_in,
  input  logic        bus_rdy
);
  typedef enum logic [1:0] {IDLE, PH1, PH2, DONE} state_t;
  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] LIMIT  = 8'(WAIT_LIMIT);
  state_t state, state_nx;
  logic [7:0] phase_cnt, wait_cnt, bank, wdata;
  logic wr, phase_end, sample, timeout;
  assign phase_end = phase_cnt == 8'd0;
  assign sample    = state == PH2 && phase_end;
  assign timeout   = wait_cnt == LIMIT;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = cmd_valid ? PH1 : IDLE;
      PH1:     state_nx = phase_end ? PH2 : PH1;
      PH2:     state_nx = !phase_end ? PH2 : (bus_rdy || timeout) ? DONE : PH1;
      default: state_nx = IDLE;
    endcase
  end
  assign cmd_ready = ARESETN && state == IDLE;
  assign rsp_valid = state == DONE;
  assign bus_phi2  = state == PH2;
  assign bus_vda   = state == PH1 || state == PH2;
  assign bus_rwb   = !(bus_vda && wr);
  assign bus_d_oe  = state == PH1 || (state == PH2 && wr);
  // bus_addr/bus_d_out are registers so they hold their last value while idle
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state     <= IDLE;
      phase_cnt <= '0;
      wait_cnt  <= '0;
      wr        <= 1'b0;
      bank      <= '0;
      wdata     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      bus_addr  <= '0;
      bus_d_out <= '0;
    end else begin
      state     <= state_nx;
      phase_cnt <= state_nx != state ? RELOAD : phase_end ? phase_cnt : phase_cnt - 8'd1;
      wait_cnt  <= state == DONE ? 8'd0 : (sample && !bus_rdy && !timeout) ? wait_cnt + 8'd1 : wait_cnt;
      if (state == IDLE && cmd_valid) begin
        wr        <= cmd_write;
        bank      <= cmd_addr[23:16];
        wdata     <= cmd_wdata;
        bus_addr  <= cmd_addr[15:0];
        bus_d_out <= cmd_addr[23:16];
      end
      if (state == PH1 && phase_end && wr)
        bus_d_out <= wdata;
      if (sample && state_nx == PH1)
        bus_d_out <= bank;
      if (sample && bus_rdy) begin
        rsp_err <= 1'b0;
        if (!wr)
          rsp_rdata <= bus_d_in;
      end else if (sample && timeout) begin
        rsp_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_w65816_bus_sequencer.sv
// tb_w65816_bus_sequencer: random commands and RDY patterns scored against a cycle-count model of the bus protocol
module tb_w65816_bus_sequencer;
  localparam int D  = 4;
  localparam int WL = 16;
  logic tb_ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, bus_rdy = 1'b1;
  logic [23:0] cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0, bus_d_in = '0;
  logic cmd_ready, rsp_valid, rsp_err, bus_phi2, bus_rwb, bus_vda, bus_d_oe;
  logic [7:0]  rsp_rdata, bus_d_out;
  logic [15:0] bus_addr;
  int errors = 0, checks = 0, cyc = 0;
  bit chk_en = 1'b0;

  typedef struct {int a; bit w; logic [23:0] addr; logic [7:0] wdata; logic [7:0] rdata; int s; bit err;} op_t;
  typedef struct {bit w; logic [23:0] addr; logic [7:0] wdata; int k; logic [7:0] dat; bit hold; int gap;} stim_t;
  op_t   sb[$];
  stim_t ops[$];
  logic [7:0]  m_rdata = '0, last_dout = '0;
  logic [15:0] last_addr = '0;

  w65816_bus_sequencer #(.CLK_DIV(D), .WAIT_LIMIT(WL)) dut (
    .ACLK(tb_ACLK), .ARESETN(ARESETN), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_phi2(bus_phi2), .bus_addr(bus_addr), .bus_rwb(bus_rwb), .bus_vda(bus_vda),
    .bus_d_out(bus_d_out), .bus_d_oe(bus_d_oe), .bus_d_in(bus_d_in), .bus_rdy(bus_rdy)
  );

  always #5 tb_ACLK = ~tb_ACLK;
  initial forever begin
    @(posedge tb_ACLK);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: bus shape from cycle position within the expected op, response popped from the scoreboard
  int mt, mdur;
  logic [7:0] mhd;
  initial forever begin
    @(negedge tb_ACLK);
    if (chk_en) begin
      if (sb.size() > 0 && cyc >= sb[0].a) begin
        mt   = cyc - sb[0].a;
        mdur = 2 * D * (sb[0].s + 1);
        mhd  = sb[0].w ? sb[0].wdata : sb[0].addr[23:16];
        if (mt < mdur) begin
          if (mt % (2 * D) < D) begin
            chk("ph1_ctl", {bus_phi2, bus_vda, bus_rwb, bus_d_oe, cmd_ready}, {1'b0, 1'b1, ~sb[0].w, 1'b1, 1'b0});
            chk("ph1_dout", bus_d_out, sb[0].addr[23:16]);
          end else begin
            chk("ph2_ctl", {bus_phi2, bus_vda, bus_rwb, bus_d_oe, cmd_ready}, {1'b1, 1'b1, ~sb[0].w, sb[0].w, 1'b0});
            chk("ph2_dout", bus_d_out, mhd);
          end
          chk("bus_addr", bus_addr, sb[0].addr[15:0]);
        end else begin
          chk("done_ctl", {bus_phi2, bus_vda, bus_rwb, bus_d_oe, cmd_ready}, 5'b00100);
          chk("done_hold", {bus_addr, bus_d_out}, {sb[0].addr[15:0], mhd});
          if (!rsp_valid) begin
            chk("rsp_missing", rsp_valid, 1);
            last_addr = sb[0].addr[15:0];
            last_dout = mhd;
            void'(sb.pop_front());
          end
        end
      end else begin
        chk("idle_ctl", {bus_phi2, bus_vda, bus_rwb, bus_d_oe, cmd_ready}, 5'b00101);
        chk("idle_hold", {bus_addr, bus_d_out}, {last_addr, last_dout});
      end
      if (rsp_valid) begin
        if (sb.size() == 0 || cyc < sb[0].a) begin
          chk("rsp_spurious", rsp_valid, 0);
        end else begin
          chk("latency", cyc - sb[0].a + 1, 2 * D * (sb[0].s + 1) + 1);
          chk("rsp_rdata", rsp_rdata, sb[0].rdata);
          chk("rsp_err", rsp_err, sb[0].err);
          last_addr = sb[0].addr[15:0];
          last_dout = sb[0].w ? sb[0].wdata : sb[0].addr[23:16];
          void'(sb.pop_front());
        end
      end
    end
  end

  function automatic stim_t mk(bit w, logic [23:0] ad, logic [7:0] wd, int k, logic [7:0] dat, bit hold, int gap);
    stim_t o;
    o.w = w; o.addr = ad; o.wdata = wd; o.k = k; o.dat = dat; o.hold = hold; o.gap = gap;
    return o;
  endfunction

  // driver: k = number of leading RDY-low samples; expected result is pushed at the accept
  task automatic run_ops(output bit ok);
    ok = 1'b1;
    for (int i = 0; i < ops.size(); i++) begin
      stim_t o, nx;
      bit nh;
      int n, e, sn;
      op_t x;
      o  = ops[i];
      nh = (i + 1 < ops.size()) && ops[i + 1].hold;
      nx = nh ? ops[i + 1] : o;
      if (!o.hold) repeat (o.gap) begin
        @(negedge tb_ACLK);
        cmd_valid = 1'b0;
      end
      @(negedge tb_ACLK);
      cmd_valid = 1'b1; cmd_write = o.w; cmd_addr = o.addr; cmd_wdata = o.wdata;
      n = 0;
      while (!cmd_ready && n < 300) begin
        @(negedge tb_ACLK);
        n++;
      end
      if (!cmd_ready) begin
        chk("accept_timeout", cmd_ready, 1);
        ok = 1'b0;
        return;
      end
      if (o.hold) chk("hold_accept_delay", n, 0);
      x.a = cyc + 1; x.w = o.w; x.addr = o.addr; x.wdata = o.wdata;
      x.err = o.k > WL;
      x.s = x.err ? WL : o.k;
      x.rdata = (!o.w && !x.err) ? o.dat : m_rdata;
      m_rdata = x.rdata;
      sb.push_back(x);
      for (int j = 0; j <= 2 * D * (x.s + 1); j++) begin
        @(negedge tb_ACLK);
        e = cyc + 1 - x.a;
        if (e % (2 * D) == 0 && e / (2 * D) <= x.s + 1) begin
          sn = e / (2 * D) - 1;
          bus_rdy  = sn >= o.k;
          bus_d_in = sn >= o.k ? o.dat : 8'($urandom);
        end else begin
          bus_rdy  = 1'($urandom);
          bus_d_in = 8'($urandom);
        end
        if (nh) begin
          cmd_valid = 1'b1; cmd_write = nx.w; cmd_addr = nx.addr; cmd_wdata = nx.wdata;
        end else begin
          cmd_valid = 1'($urandom); cmd_write = 1'($urandom); cmd_addr = 24'($urandom); cmd_wdata = 8'($urandom);
        end
      end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    bit ok, seen;
    repeat (3) @(negedge tb_ACLK);
    chk("rst_ctl", {cmd_ready, rsp_valid, rsp_err, bus_phi2, bus_vda, bus_d_oe, bus_rwb}, 7'b0000001);
    chk("rst_data", {rsp_rdata, bus_addr, bus_d_out}, 32'h0);
    ARESETN = 1'b1;
    chk_en  = 1'b1;
    ops.push_back(mk(1'b0, 24'h123456, 8'h00, 0, 8'hA5, 1'b0, 1));
    ops.push_back(mk(1'b1, 24'h00BEEF, 8'h5A, 0, 8'hFF, 1'b0, 0));
    ops.push_back(mk(1'b0, 24'h7F1234, 8'h00, 2, 8'h3C, 1'b0, 2));
    ops.push_back(mk(1'b0, 24'h010203, 8'h00, WL + 1, 8'h11, 1'b0, 0));
    ops.push_back(mk(1'b0, 24'h0A0B0C, 8'h00, 0, 8'h99, 1'b0, 0));
    ops.push_back(mk(1'b1, 24'h112233, 8'h77, 1, 8'h00, 1'b0, 1));
    ops.push_back(mk(1'b0, 24'h445566, 8'h00, 0, 8'hC3, 1'b1, 0));
    run_ops(ok);
    if (ok) begin
      // reset dropped during PH2 of a read: outputs return to reset values and no response follows
      @(negedge tb_ACLK);
      chk_en = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 24'hABCDEF; bus_rdy = 1'b1; bus_d_in = 8'h5E;
      repeat (D + 2) @(negedge tb_ACLK);
      cmd_valid = 1'b0;
      chk("pre_rst_ph2", {bus_phi2, bus_vda}, 2'b11);
      ARESETN = 1'b0;
      @(negedge tb_ACLK);
      chk("mid_rst_ctl", {cmd_ready, rsp_valid, rsp_err, bus_phi2, bus_vda, bus_d_oe, bus_rwb}, 7'b0000001);
      chk("mid_rst_data", {rsp_rdata, bus_addr, bus_d_out}, 32'h0);
      ARESETN = 1'b1;
      @(negedge tb_ACLK);
      chk("post_rst_ready", cmd_ready, 1);
      seen = 1'b0;
      repeat (2 * D + 2) begin
        @(negedge tb_ACLK);
        seen |= rsp_valid;
      end
      chk("post_rst_no_rsp", seen, 0);
      m_rdata = '0; last_addr = '0; last_dout = '0;
      sb.delete();
      chk_en = 1'b1;
      ops.delete();
      for (int i = 0; i < 40; i++) begin
        int r;
        r = int'($urandom_range(0, 7));
        ops.push_back(mk(1'($urandom), 24'($urandom), 8'($urandom), r == 0 ? WL + 1 : r % 4,
                         8'($urandom), i > 0 && $urandom_range(0, 2) == 0, int'($urandom_range(0, 2))));
      end
      run_ops(ok);
    end
    repeat (4) @(negedge tb_ACLK);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
